// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 receiver.
//   - ps2_state_e : frame FSM state encoding
//   - DATA_BITS   : data bits per PS/2 frame
//   - FIFO_DEPTH  : byte storage depth when built with PS2_RX_FIFO_EN
//   - odd_parity_ok() : odd-parity check over data + parity bit
package ps2_pkg;

    localparam int DATA_BITS  = 8;
    localparam int FIFO_DEPTH = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_e;

    // True when the data byte plus its parity bit contain an odd number of ones.
    function automatic logic odd_parity_ok(input logic [DATA_BITS-1:0] d, input logic p);
        return ^{d, p};
    endfunction

endpackage

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: FIFO_DEPTH-entry show-ahead byte FIFO (only built with PS2_RX_FIFO_EN).
// Ports:
//   clk_i, rst_i    : clock, synchronous active-high reset
//   push_i, din_i   : write strobe and byte (caller guarantees not full unless popping)
//   pop_i           : remove head entry (ignored when empty)
//   dout_o          : head entry, 0 when empty
//   valid_o         : FIFO not empty
//   full_o          : FIFO holds FIFO_DEPTH entries
module ps2_rx_fifo
    import ps2_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 push_i,
    input  logic [DATA_BITS-1:0] din_i,
    input  logic                 pop_i,
    output logic [DATA_BITS-1:0] dout_o,
    output logic                 valid_o,
    output logic                 full_o
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 do_pop;

    assign do_pop  = pop_i && (cnt_q != '0);
    assign valid_o = (cnt_q != '0);
    assign full_o  = (cnt_q == CW'(FIFO_DEPTH));
    assign dout_o  = valid_o ? mem_q[rd_ptr_q] : '0;

    always_comb begin
        cnt_d = cnt_q;
        if (push_i && !do_pop)      cnt_d = cnt_q + CW'(1);
        else if (!push_i && do_pop) cnt_d = cnt_q - CW'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= din_i;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (do_pop) rd_ptr_q <= rd_ptr_q + PW'(1);
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 device-to-host byte receiver.
// Synchronises and glitch-filters PS2_CLK, samples PS2_DAT on filtered falling
// edges, checks start/odd-parity/stop, and presents bytes on a valid/ready port.
// Build option: define PS2_RX_FIFO_EN for an 8-entry show-ahead FIFO; otherwise
// a single holding register is used.
// Ports:
//   CLOCK_50          : system clock
//   reset             : synchronous active-high reset
//   PS2_CLK, PS2_DAT  : raw asynchronous PS/2 lines
//   rx_data, rx_valid : received byte and its valid flag
//   rx_ready          : consumer accepts byte on rx_valid & rx_ready
//   frame_err         : one-cycle pulse on bad or timed-out frame
//   overflow          : one-cycle pulse when a good byte is dropped (storage full)
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                 CLOCK_50,
    input  logic                 reset,
    input  logic                 PS2_CLK,
    input  logic                 PS2_DAT,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overflow
);

    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int BW = $clog2(DATA_BITS);

    // Synchronisers (idle-high lines reset to 1)
    logic clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;

    // Clock filter
    logic          filt_q, filt_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          fall;

    // Frame FSM
    ps2_state_e           state_q, state_d;
    logic [BW-1:0]        bcnt_q, bcnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic [WW-1:0]        wd_q, wd_d;
    logic                 push;
    logic                 err_q, err_d;
    logic                 ovf_q, ovf_d;
    logic                 pop;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
        end else begin
            clk_s1_q <= PS2_CLK;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= PS2_DAT;
            dat_s2_q <= dat_s1_q;
        end
    end

    // The filtered level flips only after FILTER_LEN consecutive samples that
    // disagree with it; any agreeing sample restarts the run.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = fcnt_q;
        if (clk_s2_q == filt_q) begin
            fcnt_d = '0;
        end else if (fcnt_q == FW'(FILTER_LEN - 1)) begin
            filt_d = clk_s2_q;
            fcnt_d = '0;
        end else begin
            fcnt_d = fcnt_q + FW'(1);
        end
    end

    assign fall = filt_q && !filt_d;

    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        shift_d = shift_q;
        par_d   = par_q;
        push    = 1'b0;
        err_d   = 1'b0;
        wd_d    = (state_q == IDLE || fall) ? '0 : wd_q + WW'(1);

        case (state_q)
            IDLE: begin
                if (fall && !dat_s2_q) begin
                    state_d = DATA;
                    bcnt_d  = '0;
                end
            end
            DATA: begin
                if (fall) begin
                    shift_d = {dat_s2_q, shift_q[DATA_BITS-1:1]};
                    bcnt_d  = bcnt_q + BW'(1);
                    if (bcnt_q == BW'(DATA_BITS - 1)) state_d = PARITY;
                end
            end
            PARITY: begin
                if (fall) begin
                    par_d   = dat_s2_q;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (fall) begin
                    if (dat_s2_q && odd_parity_ok(shift_q, par_q)) push = 1'b1;
                    else                                           err_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Watchdog: a stalled frame is abandoned; a sampled edge takes priority.
        if (state_q != IDLE && !fall && wd_q == WW'(TIMEOUT_CYCLES)) begin
            err_d   = 1'b1;
            state_d = IDLE;
            wd_d    = '0;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            filt_q  <= 1'b1;
            fcnt_q  <= '0;
            state_q <= IDLE;
            bcnt_q  <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            wd_q    <= '0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            filt_q  <= filt_d;
            fcnt_q  <= fcnt_d;
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            wd_q    <= wd_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
        end
    end

    assign frame_err = err_q;
    assign overflow  = ovf_q;
    assign pop       = rx_valid && rx_ready;

`ifdef PS2_RX_FIFO_EN
    logic fifo_full;
    logic push_ok;

    // A pop in the same cycle frees the slot the push needs.
    assign push_ok = push && (!fifo_full || pop);
    assign ovf_d   = push && fifo_full && !pop;

    ps2_rx_fifo u_fifo (
        .clk_i   (CLOCK_50),
        .rst_i   (reset),
        .push_i  (push_ok),
        .din_i   (shift_q),
        .pop_i   (pop),
        .dout_o  (rx_data),
        .valid_o (rx_valid),
        .full_o  (fifo_full)
    );
`else
    logic [DATA_BITS-1:0] hold_q;
    logic                 hold_vld_q;
    logic                 hold_full;

    assign hold_full = hold_vld_q && !rx_ready;
    assign ovf_d     = push && hold_full;
    assign rx_data   = hold_q;
    assign rx_valid  = hold_vld_q;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
        end else if (push && !hold_full) begin
            hold_q     <= shift_q;
            hold_vld_q <= 1'b1;
        end else if (pop) begin
            hold_vld_q <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_ps2_rx.sv
// tb_ps2_rx: randomized scoreboard bench for ps2_rx (register or FIFO build).
module tb_ps2_rx;

    localparam int FLEN = 8;
    localparam int TMO  = 2000;
    localparam int HALF = 40;
`ifdef PS2_RX_FIFO_EN
    localparam int CAP = 8;
`else
    localparam int CAP = 1;
`endif

    logic       CLOCK_50 = 1'b0;
    logic       reset    = 1'b1;
    logic       PS2_CLK  = 1'b1;
    logic       PS2_DAT  = 1'b1;
    logic       rx_ready = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overflow;

    ps2_rx #(.FILTER_LEN(FLEN), .TIMEOUT_CYCLES(TMO)) dut (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .PS2_CLK   (PS2_CLK),
        .PS2_DAT   (PS2_DAT),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overflow  (overflow)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge CLOCK_50) cyc++;

    // Reference model state
    logic [7:0] exp_q[$];
    int  exp_err = 0, exp_ovf = 0, occ = 0;
    bit  hold_mode = 0;

    // Monitor observations
    int  err_seen = 0, ovf_seen = 0, vld_cycles = 0;
    int  last_vld_rise = 0, last_fall_cyc = 0;
    logic       prev_vld = 0, prev_rdy = 0;
    logic [7:0] prev_data = 0;
    bit  rand_rdy = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor
    always @(negedge CLOCK_50) begin
        if (reset) begin
            prev_vld = 1'b0;
        end else begin
            if (frame_err) err_seen++;
            if (overflow)  ovf_seen++;
            if (rx_valid)  vld_cycles++;
            if (rx_valid && !prev_vld) last_vld_rise = cyc;
            if (prev_vld && !prev_rdy) begin
                chk("hold_valid", {31'd0, rx_valid}, 32'd1);
                chk("hold_data", {24'd0, rx_data}, {24'd0, prev_data});
            end
            if (rx_valid && rx_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_byte: got %0h expected none", rx_data);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    chk("rx_data", {24'd0, rx_data}, {24'd0, e});
                end
            end
            prev_vld  = rx_valid;
            prev_rdy  = rx_ready;
            prev_data = rx_data;
        end
    end

    always @(posedge CLOCK_50) if (rand_rdy) begin
        #1 rx_ready = 1'($urandom_range(0, 1));
    end

    initial begin
        repeat (90000) @(posedge CLOCK_50);
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    // Drive nbits of an 11-bit frame (bit0 = start); optional 3-cycle clock
    // glitch inside the high phase of bit glitch_bit.
    task automatic send_bits(input logic [10:0] bits, input int nbits, input int glitch_bit);
        for (int i = 0; i < nbits; i++) begin
            PS2_DAT = bits[i];
            if (i == glitch_bit) begin
                tick(10);
                PS2_CLK = 1'b0;
                tick(3);
                PS2_CLK = 1'b1;
                tick(HALF - 13);
            end else begin
                tick(HALF);
            end
            PS2_CLK = 1'b0;
            if (i == 10) last_fall_cyc = cyc;
            tick(HALF);
            PS2_CLK = 1'b1;
        end
        PS2_DAT = 1'b1;
        tick(HALF);
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
        logic p;
        p = 1'b1;
        for (int i = 0; i < 8; i++) p = p ^ d[i];   // odd parity bit
        return {~bad_stop, p ^ bad_par, d, 1'b0};
    endfunction

    // Model: a good frame is delivered unless storage is full; bad frames error.
    task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop, input int glitch_bit);
        if (bad_par || bad_stop) begin
            exp_err++;
        end else if (!hold_mode) begin
            exp_q.push_back(d);
        end else if (occ < CAP) begin
            exp_q.push_back(d);
            occ++;
        end else begin
            exp_ovf++;
        end
        send_bits(mk_frame(d, bad_par, bad_stop), 11, glitch_bit);
    endtask

    initial begin
        int v0;
        tick(5);
        chk("rst_rx_data", {24'd0, rx_data}, 32'd0);
        chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        reset = 1'b0;
        tick(5);

        // Single good byte, latency and one-cycle valid
        v0 = vld_cycles;
        send_frame(8'h1C, 0, 0, -1);
        tick(20);
        chk("latency", last_vld_rise - last_fall_cyc, 2 + FLEN);
        chk("valid_one_cycle", vld_cycles - v0, 1);
        chk("t1_err", err_seen, exp_err);
        chk("t1_drained", exp_q.size(), 0);

        // Bad parity, bad stop
        v0 = vld_cycles;
        send_frame(8'hF0, 1, 0, -1);
        send_frame(8'h5A, 0, 1, -1);
        tick(20);
        chk("t2_err", err_seen, exp_err);
        chk("t2_no_valid", vld_cycles - v0, 0);

        // Truncated frame then watchdog
        send_bits(mk_frame(8'h29, 0, 0), 5, -1);
        exp_err++;
        tick(TMO + 200);
        chk("t3_timeout_err", err_seen, exp_err);
        send_frame(8'h29, 0, 0, -1);
        tick(20);
        chk("t3_err", err_seen, exp_err);
        chk("t3_drained", exp_q.size(), 0);

        // Glitch on clock
        send_frame(8'h45, 0, 0, 4);
        tick(20);
        chk("t4_err", err_seen, exp_err);
        chk("t4_drained", exp_q.size(), 0);

        // Storage fill with consumer stalled
        rx_ready  = 1'b0;
        hold_mode = 1;
        occ       = 0;
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 0, 0, -1);
        tick(20);
        chk("t5_overflow", ovf_seen, exp_ovf);
        chk("t5_ovf_count", exp_ovf, 9 - CAP);
        chk("t5_head", {24'd0, rx_data}, 32'h01);
        chk("t5_valid", {31'd0, rx_valid}, 32'd1);
        hold_mode = 0;
        rx_ready  = 1'b1;
        tick(20);
        chk("t5_drained", exp_q.size(), 0);

        // Reset mid-frame
        send_bits(mk_frame(8'h76, 0, 0), 6, -1);
        reset = 1'b1;
        tick(3);
        chk("t6_rx_data", {24'd0, rx_data}, 32'd0);
        chk("t6_rx_valid", {31'd0, rx_valid}, 32'd0);
        chk("t6_frame_err", {31'd0, frame_err}, 32'd0);
        reset = 1'b0;
        tick(5);
        send_frame(8'h76, 0, 0, -1);
        tick(20);
        chk("t6_err", err_seen, exp_err);
        chk("t6_drained", exp_q.size(), 0);

        // Randomized frames with random backpressure
        rand_rdy = 1;
        for (int i = 0; i < 16; i++) begin
            int k;
            k = $urandom_range(0, 5);
            send_frame(8'($urandom), k == 0, k == 1, -1);
        end
        rand_rdy = 0;
        tick(2);
        rx_ready = 1'b1;
        tick(20);
        chk("t7_err", err_seen, exp_err);
        chk("t7_overflow", ovf_seen, exp_ovf);
        chk("t7_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
